multicycle_control_fsm: RTL and testbench

Main control state machine of the multi-cycle RISC-V core. Steps each instruction through IF/ID/EX/MEM/WB and drives the datapath control signals:
- PC, IR and memory strobes
- select lines of the ALU-operand muxes, the PC-source mux and the write-back mux
- retire/halt status

Consumes the latched IR opcode, the ALU branch condition, the ecall-halt compare result and the memory ready handshake.

---
 rtl/multicycle_control_fsm_pkg.sv | 49 ++++
 rtl/multicycle_perf_counters.sv | 23 ++
 rtl/multicycle_control_fsm.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RISC-V control FSM: states, opcodes
// and datapath mux select values.
package multicycle_control_fsm_pkg;

  typedef enum logic [2:0] {
    S_IF     = 3'd0,
    S_ID     = 3'd1,
    S_EX     = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BTAKEN = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10
  } alu_src_b_e;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_FUNCT  = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MDR = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  // Opcodes that need an EX step; anything else retires as a NOP in ID.
  function automatic logic needsEx(input logic [6:0] op);
    return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL) ||
           (op == OP_JALR);
  endfunction

endpackage

// File: rtl/multicycle_perf_counters.sv
// Free-running cycle and retired-instruction counters; both wrap at 2^CNT_W.
module multicycle_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cycleInc,
  input  logic             retireInc,
  output logic [CNT_W-1:0] cycleCnt,
  output logic [CNT_W-1:0] instret
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycleCnt <= '0;
      instret  <= '0;
    end else begin
      if (cycleInc)  cycleCnt <= cycleCnt + 1'b1;
      if (retireInc) instret  <= instret + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main IF/ID/EX/MEM/WB control FSM of the multi-cycle core.
// Define MULTICYCLE_PERF_COUNTER_EN to add cycle/instret counter outputs.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       opcode_i,
  input  logic             bcond_i,
  input  logic             ecall_halt_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_source_o,
  output logic             i_or_d_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             mdr_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic             reg_write_o,
  output logic [1:0]       wb_sel_o,
  output logic             halted_o,
  output logic [2:0]       state_o
`ifdef MULTICYCLE_PERF_COUNTER_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_o
`endif
);

  state_e     state, nextState;
  logic       pcWrite, pcSource, iOrD, memRead, memWrite, irWrite, mdrWrite;
  logic       srcA, regWrite;
  alu_src_b_e srcB;
  alu_op_e    aluOp;
  wb_sel_e    wbSel;
  logic       halted;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IF;
      halted <= 1'b0;
    end else begin
      state <= nextState;
      if (nextState == S_HALT) halted <= 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    pcWrite   = 1'b0;
    pcSource  = 1'b0;
    iOrD      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    mdrWrite  = 1'b0;
    srcA      = 1'b0;
    srcB      = SRCB_RS2;
    aluOp     = ALUOP_ADD;
    regWrite  = 1'b0;
    wbSel     = WB_ALU;
    case (state)
      S_IF: begin
        memRead = 1'b1;
        irWrite = mem_ready_i;
        if (mem_ready_i) nextState = S_ID;
      end
      S_ID: begin
        if (opcode_i == OP_ECALL && ecall_halt_i) begin
          nextState = S_HALT;
        end else if (opcode_i == OP_ECALL || !needsEx(opcode_i)) begin
          pcWrite   = 1'b1;
          nextState = S_IF;
        end else begin
          nextState = S_EX;
        end
      end
      S_EX: begin
        case (opcode_i)
          OP_R: begin
            srcA = 1'b1; aluOp = ALUOP_FUNCT; nextState = S_WB;
          end
          OP_IMM: begin
            srcA = 1'b1; srcB = SRCB_IMM; aluOp = ALUOP_FUNCT; nextState = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            srcA = 1'b1; srcB = SRCB_IMM; nextState = S_MEM;
          end
          OP_BRANCH: begin
            srcA  = 1'b1;
            aluOp = ALUOP_BRANCH;
            if (bcond_i) begin
              nextState = S_BTAKEN;
            end else begin
              pcWrite   = 1'b1;
              nextState = S_IF;
            end
          end
          OP_JAL, OP_JALR: begin
            // Link value comes from the PC+4 path while the ALU forms the target.
            srcA      = (opcode_i == OP_JALR);
            srcB      = SRCB_IMM;
            pcWrite   = 1'b1;
            pcSource  = 1'b1;
            regWrite  = 1'b1;
            wbSel     = WB_PC4;
            nextState = S_IF;
          end
          default: begin
            pcWrite   = 1'b1;
            nextState = S_IF;
          end
        endcase
      end
      S_MEM: begin
        iOrD     = 1'b1;
        memRead  = (opcode_i == OP_LOAD);
        memWrite = (opcode_i == OP_STORE);
        if (mem_ready_i) begin
          if (opcode_i == OP_LOAD) begin
            mdrWrite  = 1'b1;
            nextState = S_WB;
          end else begin
            pcWrite   = (opcode_i == OP_STORE);
            nextState = S_IF;
          end
        end
      end
      S_WB: begin
        regWrite  = 1'b1;
        wbSel     = (opcode_i == OP_LOAD) ? WB_MDR : WB_ALU;
        pcWrite   = 1'b1;
        nextState = S_IF;
      end
      S_BTAKEN: begin
        srcB      = SRCB_IMM;
        pcWrite   = 1'b1;
        pcSource  = 1'b1;
        nextState = S_IF;
      end
      S_HALT: nextState = S_HALT;
      default: nextState = S_IF;
    endcase
  end

  // Reset masks every strobe combinationally so an abort writes nothing.
  always_comb begin
    pc_write_o  = reset_n & pcWrite;
    pc_source_o = reset_n & pcSource;
    i_or_d_o    = reset_n & iOrD;
    mem_read_o  = reset_n & memRead;
    mem_write_o = reset_n & memWrite;
    ir_write_o  = reset_n & irWrite;
    mdr_write_o = reset_n & mdrWrite;
    alu_src_a_o = reset_n & srcA;
    alu_src_b_o = reset_n ? srcB  : 2'b00;
    alu_op_o    = reset_n ? aluOp : 2'b00;
    reg_write_o = reset_n & regWrite;
    wb_sel_o    = reset_n ? wbSel : 2'b00;
    state_o     = reset_n ? state : S_IF;
    halted_o    = halted;
  end

`ifdef MULTICYCLE_PERF_COUNTER_EN
  logic enterHalt;
  assign enterHalt = (state != S_HALT) && (nextState == S_HALT);

  multicycle_perf_counters #(.CNT_W(CNT_W)) uPerf (
    .clk       (clk),
    .reset_n   (reset_n),
    .cycleInc  (state != S_HALT),
    .retireInc (pc_write_o | enterHalt),
    .cycleCnt  (cycle_cnt_o),
    .instret   (instret_o)
  );
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: stimulus pushes the expected
// per-cycle control word, a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

  localparam int CNT_W = 32;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] IMM = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JLR = 7'b1100111;
  localparam logic [6:0] ECL = 7'b1110011;
  localparam logic [6:0] BAD = 7'b0000000;

  typedef struct packed {
    logic [2:0] st;
    logic       halted, pcW, pcS, iod, mr, mw, irw, mdrw, a;
    logic [1:0] b, op;
    logic       rw;
    logic [1:0] wb;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [6:0] opcode = '0;
  logic bcond = 1'b0, ecallHalt = 1'b0, memReady = 1'b0;
  logic pcWrite, pcSource, iOrD, memRead, memWrite, irWrite, mdrWrite, srcA;
  logic [1:0] srcB, aluOp, wbSel;
  logic regWrite, halted;
  logic [2:0] state;
`ifdef MULTICYCLE_PERF_COUNTER_EN
  logic [CNT_W-1:0] cycleCnt, instret;
`endif

  int checks = 0;
  int errors = 0;
  obs_t sb[$];

  always #5 clk = ~clk;

  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .opcode_i(opcode), .bcond_i(bcond),
    .ecall_halt_i(ecallHalt), .mem_ready_i(memReady),
    .pc_write_o(pcWrite), .pc_source_o(pcSource), .i_or_d_o(iOrD),
    .mem_read_o(memRead), .mem_write_o(memWrite), .ir_write_o(irWrite),
    .mdr_write_o(mdrWrite), .alu_src_a_o(srcA), .alu_src_b_o(srcB),
    .alu_op_o(aluOp), .reg_write_o(regWrite), .wb_sel_o(wbSel),
    .halted_o(halted), .state_o(state)
`ifdef MULTICYCLE_PERF_COUNTER_EN
    , .cycle_cnt_o(cycleCnt), .instret_o(instret)
`endif
  );

  // Hand-written expected control words per state.
  function automatic obs_t oRst();
    return '0;
  endfunction
  function automatic obs_t oIF(input logic rdy);
    obs_t o = '0; o.mr = 1'b1; o.irw = rdy; return o;
  endfunction
  function automatic obs_t oID(input logic ret);
    obs_t o = '0; o.st = 3'd1; o.pcW = ret; return o;
  endfunction
  function automatic obs_t oExR();
    obs_t o = '0; o.st = 3'd2; o.a = 1'b1; o.op = 2'b10; return o;
  endfunction
  function automatic obs_t oExI();
    obs_t o = '0; o.st = 3'd2; o.a = 1'b1; o.b = 2'b10; o.op = 2'b10; return o;
  endfunction
  function automatic obs_t oExLS();
    obs_t o = '0; o.st = 3'd2; o.a = 1'b1; o.b = 2'b10; return o;
  endfunction
  function automatic obs_t oExB(input logic taken);
    obs_t o = '0; o.st = 3'd2; o.a = 1'b1; o.op = 2'b01; o.pcW = ~taken; return o;
  endfunction
  function automatic obs_t oExJ(input logic a);
    obs_t o = '0; o.st = 3'd2; o.a = a; o.b = 2'b10; o.pcW = 1'b1; o.pcS = 1'b1;
    o.rw = 1'b1; o.wb = 2'b10; return o;
  endfunction
  function automatic obs_t oMem(input logic isLoad, input logic rdy);
    obs_t o = '0; o.st = 3'd3; o.iod = 1'b1; o.mr = isLoad; o.mw = ~isLoad;
    o.mdrw = isLoad & rdy; o.pcW = ~isLoad & rdy; return o;
  endfunction
  function automatic obs_t oWB(input logic isLoad);
    obs_t o = '0; o.st = 3'd4; o.rw = 1'b1; o.wb = isLoad ? 2'b01 : 2'b00;
    o.pcW = 1'b1; return o;
  endfunction
  function automatic obs_t oBT();
    obs_t o = '0; o.st = 3'd5; o.b = 2'b10; o.pcW = 1'b1; o.pcS = 1'b1; return o;
  endfunction
  function automatic obs_t oHalt();
    obs_t o = '0; o.st = 3'd6; o.halted = 1'b1; return o;
  endfunction

  task automatic cyc(input logic [6:0] op, input logic bc, input logic eh,
                     input logic rdy, input logic rn, input obs_t e);
    @(posedge clk);
    #1;
    opcode = op; bcond = bc; ecallHalt = eh; memReady = rdy; reset_n = rn;
    sb.push_back(e);
  endtask

  // Monitor: every cycle presents a control word; compare it mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      obs_t e, act;
      e = sb.pop_front();
      act = '{st: state, halted: halted, pcW: pcWrite, pcS: pcSource, iod: iOrD,
              mr: memRead, mw: memWrite, irw: irWrite, mdrw: mdrWrite, a: srcA,
              b: srcB, op: aluOp, rw: regWrite, wb: wbSel};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL ctrl t=%0t got=%h exp=%h (st %0d vs %0d)",
                 $time, act, e, act.st, e.st);
      end
`ifdef MULTICYCLE_PERF_COUNTER_EN
      if (e == '0) begin
        checks++;
        if (cycleCnt !== '0 || instret !== '0) begin
          errors++;
          $display("FAIL perf_rst cycle=%0d instret=%0d exp=0/0", cycleCnt, instret);
        end
      end
`endif
    end
  end

  initial begin
    #2 reset_n = 1'b0;
    // Reset held with memory ready: nothing may move.
    repeat (3) cyc(R, 0, 0, 1, 0, oRst());
    // R-type, zero wait: 0,1,2,4
    cyc(R, 0, 0, 1, 1, oIF(1)); cyc(R, 0, 0, 1, 1, oID(0));
    cyc(R, 0, 0, 1, 1, oExR()); cyc(R, 0, 0, 1, 1, oWB(0));
    // I-arith with one fetch wait
    cyc(IMM, 0, 0, 0, 1, oIF(0)); cyc(IMM, 0, 0, 1, 1, oIF(1));
    cyc(IMM, 0, 0, 0, 1, oID(0)); cyc(IMM, 0, 0, 0, 1, oExI()); cyc(IMM, 0, 0, 0, 1, oWB(0));
    // LOAD with two MEM wait cycles: 7 cycles
    cyc(LD, 0, 0, 1, 1, oIF(1)); cyc(LD, 0, 0, 1, 1, oID(0)); cyc(LD, 0, 0, 1, 1, oExLS());
    cyc(LD, 0, 0, 0, 1, oMem(1, 0)); cyc(LD, 0, 0, 0, 1, oMem(1, 0));
    cyc(LD, 0, 0, 1, 1, oMem(1, 1)); cyc(LD, 0, 0, 1, 1, oWB(1));
    // STORE zero wait
    cyc(ST, 0, 0, 1, 1, oIF(1)); cyc(ST, 0, 0, 1, 1, oID(0));
    cyc(ST, 0, 0, 1, 1, oExLS()); cyc(ST, 0, 0, 1, 1, oMem(0, 1));
    // Branch not taken / taken
    cyc(BR, 0, 0, 1, 1, oIF(1)); cyc(BR, 0, 0, 1, 1, oID(0)); cyc(BR, 0, 0, 1, 1, oExB(0));
    cyc(BR, 1, 0, 1, 1, oIF(1)); cyc(BR, 1, 0, 1, 1, oID(0));
    cyc(BR, 1, 0, 1, 1, oExB(1)); cyc(BR, 1, 0, 1, 1, oBT());
    // JAL / JALR
    cyc(JAL, 0, 0, 1, 1, oIF(1)); cyc(JAL, 0, 0, 1, 1, oID(0)); cyc(JAL, 0, 0, 1, 1, oExJ(0));
    cyc(JLR, 0, 0, 1, 1, oIF(1)); cyc(JLR, 0, 0, 1, 1, oID(0)); cyc(JLR, 0, 0, 1, 1, oExJ(1));
    // Unknown opcode retires as NOP in ID
    cyc(BAD, 0, 0, 1, 1, oIF(1)); cyc(BAD, 0, 0, 1, 1, oID(1));
    // ECALL without halt
    cyc(ECL, 0, 0, 1, 1, oIF(1)); cyc(ECL, 0, 0, 1, 1, oID(1));
    // ECALL with halt: absorbing, memory ready toggling is ignored
    cyc(ECL, 0, 1, 1, 1, oIF(1)); cyc(ECL, 0, 1, 1, 1, oID(0));
    for (int i = 0; i < 11; i++) cyc(R, i[0], i[1], i[0], 1, oHalt());
    // Reset pulse leaves HALT
    cyc(R, 0, 0, 1, 0, oRst()); cyc(R, 0, 0, 1, 1, oIF(1));
    cyc(R, 0, 0, 1, 1, oID(0)); cyc(R, 0, 0, 1, 1, oExR()); cyc(R, 0, 0, 1, 1, oWB(0));
    // STORE aborted by reset while waiting in MEM
    cyc(ST, 0, 0, 1, 1, oIF(1)); cyc(ST, 0, 0, 1, 1, oID(0)); cyc(ST, 0, 0, 0, 1, oExLS());
    cyc(ST, 0, 0, 0, 1, oMem(0, 0)); cyc(ST, 0, 0, 1, 0, oRst()); cyc(ST, 0, 0, 1, 0, oRst());
    cyc(ST, 0, 0, 1, 1, oIF(1)); cyc(ST, 0, 0, 1, 1, oID(0));
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
